ws2812b_rx_64: RTL and testbench

WS2812B_RX_64 -- requirements
Module: ws2812b_rx_64

---
 rtl/ws2812b_rx_64_pkg.sv | 35 +++
 rtl/ws2812b_pulse_meter.sv | 65 ++++++
 rtl/ws2812b_rx_64.sv | 191 +++++++++++++++++++
 tb/tb_ws2812b_rx_64.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_rx_64_pkg.sv
// Shared definitions for the 64-LED WS2812B link: receiver FSM encoding,
// default pulse-timing limits (in 50 MHz clock cycles) and frame geometry.
// The transmitter model uses the same constants, so both ends agree on them.
package ws2812b_rx_64_pkg;

    // Receiver states: SYNC waits for a clean latch gap, IDLE waits for the
    // first bit of a frame, HIGH measures a pulse, LOW measures the gap after it.
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } rx_state_t;

    // Longest high pulse still read as a 0 bit.
    localparam int T0H_MAX_DEF = 30;
    // Longest high pulse still read as a 1 bit; anything longer is a fault.
    localparam int T1H_MAX_DEF = 55;
    // High pulses shorter than this are line glitches.
    localparam int TH_MIN_DEF  = 8;
    // Low time that closes a frame (50 us at 50 MHz).
    localparam int TLATCH_DEF  = 2500;
    // Pixels per frame and bits per pixel (G7..G0, R7..R0, B7..B0).
    localparam int NLED_DEF    = 64;
    localparam int PIXEL_BITS  = 24;
    // Width of the pulse and gap measurement counters.
    localparam int WIDTH_BITS  = 16;

    // Counter increment that sticks at all-ones instead of wrapping, so a
    // line stuck in one level can never alias back to a short pulse.
    function automatic logic [WIDTH_BITS-1:0] sat_inc(input logic [WIDTH_BITS-1:0] value);
        return (value == {WIDTH_BITS{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ws2812b_pulse_meter.sv
// Front end of the WS2812B receiver: brings the asynchronous serial line into
// the clock domain, flags its edges, and measures how long it stays high and
// how long it stays low. The low counter is steered by the FSM so that a
// rejected glitch does not throw away the low time already accumulated.
module ws2812b_pulse_meter
    import ws2812b_rx_64_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  low_clr,
    output logic                  level,
    output logic                  rise,
    output logic                  fall,
    output logic [WIDTH_BITS-1:0] high_cnt,
    output logic [WIDTH_BITS-1:0] low_cnt
);

    logic [1:0]            sync_reg;
    logic                  prev_reg;
    logic [WIDTH_BITS-1:0] high_cnt_reg;
    logic [WIDTH_BITS-1:0] low_cnt_reg;

    // Two-flop synchronizer plus a one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            prev_reg <= sync_reg[1];
        end
    end

    assign level = sync_reg[1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

    // High width: restarts at 1 on a rising edge and holds its value while
    // the line is low, so the FSM reads the finished width in the fall cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt_reg <= '0;
        end else if (level) begin
            high_cnt_reg <= rise ? WIDTH_BITS'(1) : sat_inc(high_cnt_reg);
        end
    end

    // Low width: counts low cycles and freezes during high cycles. The FSM
    // restarts it (to 1 in a low cycle, 0 in a high cycle) when a pulse is
    // accepted or while it is resynchronising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_reg <= '0;
        end else if (low_clr) begin
            low_cnt_reg <= level ? '0 : WIDTH_BITS'(1);
        end else if (!level) begin
            low_cnt_reg <= sat_inc(low_cnt_reg);
        end
    end

    assign high_cnt = high_cnt_reg;
    assign low_cnt  = low_cnt_reg;

endmodule

// File: rtl/ws2812b_rx_64.sv
// WS2812B receiver for frames of up to NLED pixels. Decodes high-pulse widths
// into bits, assembles 24-bit pixels (first received bit in pixel_data[0]),
// and reports pixel strobes, frame completion on the latch gap, and faults.
module ws2812b_rx_64
    import ws2812b_rx_64_pkg::*;
#(
    parameter int T0H_MAX = T0H_MAX_DEF,
    parameter int T1H_MAX = T1H_MAX_DEF,
    parameter int TH_MIN  = TH_MIN_DEF,
    parameter int TLATCH  = TLATCH_DEF,
    parameter int NLED    = NLED_DEF
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    output logic [0:PIXEL_BITS-1] pixel_data,
    output logic [5:0]            pixel_index,
    output logic                  pixel_valid,
    output logic                  frame_done,
    output logic [6:0]            pixel_count,
    output logic                  error
);

    localparam logic [WIDTH_BITS-1:0] T0H_LIM    = WIDTH_BITS'(T0H_MAX);
    localparam logic [WIDTH_BITS-1:0] T1H_LIM    = WIDTH_BITS'(T1H_MAX);
    localparam logic [WIDTH_BITS-1:0] TH_MIN_LIM = WIDTH_BITS'(TH_MIN);
    localparam logic [WIDTH_BITS-1:0] TLATCH_LIM = WIDTH_BITS'(TLATCH);
    localparam logic [6:0]            NLED_LIM   = 7'(NLED);
    localparam logic [4:0]            LAST_BIT   = 5'(PIXEL_BITS - 1);

    // Pulse measurement front end.
    logic                  level;
    logic                  rise;
    logic                  fall;
    logic                  low_clr;
    logic [WIDTH_BITS-1:0] high_cnt;
    logic [WIDTH_BITS-1:0] low_cnt;

    // FSM state and frame bookkeeping.
    rx_state_t             state_reg;
    logic                  from_low_reg;
    logic [4:0]            bit_cnt_reg;
    logic [6:0]            pix_cnt_reg;
    logic [0:PIXEL_BITS-1] shift_reg;

    // Registered outputs.
    logic [0:PIXEL_BITS-1] pixel_data_reg;
    logic [5:0]            pixel_index_reg;
    logic                  pixel_valid_reg;
    logic                  frame_done_reg;
    logic [6:0]            pixel_count_reg;
    logic                  error_reg;

    // Decode helpers for the pulse that ends in the current cycle.
    logic                  pulse_glitch;
    logic                  pulse_too_long;
    logic                  bit_value;
    logic [0:PIXEL_BITS-1] shift_next;
    logic                  latch_gap;
    logic [6:0]            pix_cnt_inc;
    logic [6:0]            pix_cnt_clamped;

    ws2812b_pulse_meter u_meter (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .low_clr  (low_clr),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .high_cnt (high_cnt),
        .low_cnt  (low_cnt)
    );

    assign pulse_glitch    = (high_cnt < TH_MIN_LIM);
    assign pulse_too_long  = (high_cnt > T1H_LIM);
    assign bit_value       = (high_cnt > T0H_LIM);
    assign shift_next      = {shift_reg[1:PIXEL_BITS-1], bit_value};
    assign latch_gap       = (low_cnt >= TLATCH_LIM);
    assign pix_cnt_inc     = (pix_cnt_reg == 7'h7F) ? pix_cnt_reg : pix_cnt_reg + 7'd1;
    assign pix_cnt_clamped = (pix_cnt_reg > NLED_LIM) ? NLED_LIM : pix_cnt_reg;

    // Restart the low-time measurement while resynchronising on a high line,
    // and when a real (non-glitch) pulse ends: its fall cycle is low cycle 1.
    assign low_clr = ((state_reg == ST_SYNC) && level) ||
                     ((state_reg == ST_HIGH) && fall && !pulse_glitch);

    // Receiver FSM: bit decode, pixel assembly, frame close and fault handling.
    // A pixel strobe is issued from HIGH and a frame close from LOW, with the
    // low counter at least 1 in between, so the two strobes always land in
    // different cycles with the pixel first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_SYNC;
            from_low_reg    <= 1'b0;
            bit_cnt_reg     <= '0;
            pix_cnt_reg     <= '0;
            shift_reg       <= '0;
            pixel_data_reg  <= '0;
            pixel_index_reg <= '0;
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            pixel_count_reg <= '0;
            error_reg       <= 1'b0;
        end else begin
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            error_reg       <= 1'b0;
            case (state_reg)
                ST_SYNC: begin
                    bit_cnt_reg <= '0;
                    pix_cnt_reg <= '0;
                    if (latch_gap) begin
                        // A rise in the very cycle the gap completes still
                        // starts the first bit.
                        if (rise) begin
                            state_reg    <= ST_HIGH;
                            from_low_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    bit_cnt_reg <= '0;
                    pix_cnt_reg <= '0;
                    if (rise) begin
                        state_reg    <= ST_HIGH;
                        from_low_reg <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (pulse_too_long) begin
                        // Over-long pulse: drop the partial pixel and wait for
                        // a full latch gap before trusting the line again.
                        error_reg   <= 1'b1;
                        state_reg   <= ST_SYNC;
                        bit_cnt_reg <= '0;
                        pix_cnt_reg <= '0;
                    end else if (fall) begin
                        if (pulse_glitch) begin
                            state_reg <= from_low_reg ? ST_LOW : ST_IDLE;
                        end else begin
                            shift_reg <= shift_next;
                            state_reg <= ST_LOW;
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg <= '0;
                                pix_cnt_reg <= pix_cnt_inc;
                                if (pix_cnt_reg < NLED_LIM) begin
                                    pixel_data_reg  <= shift_next;
                                    pixel_index_reg <= pix_cnt_reg[5:0];
                                    pixel_valid_reg <= 1'b1;
                                end else if (pix_cnt_reg == NLED_LIM) begin
                                    // Only the first excess pixel is flagged.
                                    error_reg <= 1'b1;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_reg    <= ST_HIGH;
                        from_low_reg <= 1'b1;
                    end else if (latch_gap) begin
                        frame_done_reg  <= 1'b1;
                        pixel_count_reg <= pix_cnt_clamped;
                        error_reg       <= (bit_cnt_reg != 5'd0);
                        bit_cnt_reg     <= '0;
                        pix_cnt_reg     <= '0;
                        state_reg       <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_SYNC;
                end
            endcase
        end
    end

    assign pixel_data  = pixel_data_reg;
    assign pixel_index = pixel_index_reg;
    assign pixel_valid = pixel_valid_reg;
    assign frame_done  = frame_done_reg;
    assign pixel_count = pixel_count_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_ws2812b_rx_64.sv
// Bench for ws2812b_rx_64: each scenario is a list of line segments (level and
// duration, or a reset). The same list drives the DUT and a pulse-level
// reference model that applies the decoding rules to whole pulse widths.
module tb_ws2812b_rx_64;

    localparam int T0H_MAX = 30;
    localparam int T1H_MAX = 55;
    localparam int TH_MIN  = 8;
    localparam int TLATCH  = 2500;
    localparam int NLED    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [0:23] pixel_data;
    logic [5:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [6:0]  pixel_count;
    logic        error;

    always #10 clk = ~clk;

    ws2812b_rx_64 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_index (pixel_index),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .pixel_count (pixel_count),
        .error       (error)
    );

    // lvl: 0 = low, 1 = high, 2 = reset pulse
    typedef struct { int lvl; int n; } seg_t;
    typedef struct { logic [23:0] data; int idx; } pix_t;
    typedef struct { int cnt; int err; } frm_t;
    typedef struct {
        int kind;
        int exp_valid;
        int exp_frames;
        int exp_errors;
        int exp_count;
    } vec_t;

    seg_t segs[$];
    pix_t exp_pix[$];
    pix_t dut_pix[$];
    frm_t exp_frm[$];
    frm_t dut_frm[$];
    int   exp_err;
    int   dut_err = 0;
    int   dut_clash = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: one record per output strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_valid) dut_pix.push_back('{data: pixel_data, idx: int'(pixel_index)});
            if (frame_done) dut_frm.push_back('{cnt: int'(pixel_count), err: int'(error)});
            if (error) dut_err = dut_err + 1;
            if (pixel_valid && frame_done) dut_clash = dut_clash + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_seg(input int lvl, input int n);
        segs.push_back('{lvl: lvl, n: n});
    endtask

    // mode 0: nominal 20/43 and 40/23; mode 1: shortest legal widths;
    // mode 2: random widths across the whole legal range of each symbol.
    task automatic add_bit(input bit b, input int mode);
        int h;
        int l;
        if (mode == 0) begin
            h = b ? 40 : 20;
            l = b ? 23 : 43;
        end else if (mode == 1) begin
            h = b ? T0H_MAX + 1 : TH_MIN;
            l = 2;
        end else begin
            h = b ? int'($urandom_range(T1H_MAX, T0H_MAX + 1)) : int'($urandom_range(T0H_MAX, TH_MIN));
            l = int'($urandom_range(20, 2));
        end
        add_seg(1, h);
        add_seg(0, l);
    endtask

    task automatic add_pixel(input logic [23:0] v, input int mode);
        for (int j = 23; j >= 0; j--) add_bit(v[j], mode);
    endtask

    task automatic build(input int kind);
        segs.delete();
        add_seg(2, 3);
        case (kind)
            0: begin
                add_seg(0, TLATCH);
                add_pixel(24'hFF0000, 0);
                add_seg(0, 5000);
            end
            1: begin
                add_seg(0, 2600);
                for (int i = 0; i < NLED + 1; i++) add_pixel({i[7:0], i[7:0], i[7:0]}, 1);
                add_seg(0, 2600);
            end
            2: begin
                add_seg(0, 2600);
                add_pixel(24'($urandom), 1);
                add_seg(0, 20);
                add_seg(1, 5);
                add_seg(0, 20);
                add_pixel(24'($urandom), 1);
                for (int i = 0; i < 10; i++) add_bit(1'($urandom), 1);
                add_seg(1, 70);
                add_seg(0, 1000);
                for (int i = 0; i < 8; i++) add_bit(1'($urandom), 1);
                add_seg(0, 2600);
                add_pixel(24'($urandom), 1);
                add_seg(0, 2600);
            end
            3: begin
                add_seg(0, 2600);
                for (int i = 0; i < 12; i++) add_bit(1'($urandom), 2);
                add_seg(0, 2600);
            end
            4: begin
                add_seg(0, 2600);
                for (int i = 0; i < 5; i++) add_pixel(24'($urandom), 2);
                add_seg(0, 2600);
            end
            default: begin
                add_seg(0, 2600);
                for (int i = 0; i < 100; i++) add_bit(1'($urandom), 2);
                add_seg(2, 3);
                for (int i = 0; i < 50; i++) add_bit(1'($urandom), 2);
                add_seg(0, 2600);
                for (int i = 0; i < 2; i++) add_pixel(24'($urandom), 2);
                add_seg(0, 2600);
            end
        endcase
    endtask

    // Reference model working on whole pulses: classify each high pulse by its
    // width, accumulate low time between accepted pulses, close a frame when
    // the accumulated low time reaches the latch length.
    task automatic model_run();
        bit          in_sync = 1'b1;
        bit          in_frame = 1'b0;
        int          lowrun = 0;
        int          nbits = 0;
        int          npix = 0;
        logic [23:0] cur = '0;
        exp_pix.delete();
        exp_frm.delete();
        exp_err = 0;
        foreach (segs[k]) begin
            if (segs[k].lvl == 2) begin
                in_sync = 1'b1; in_frame = 1'b0; lowrun = 0; nbits = 0; npix = 0;
            end else if (segs[k].lvl == 0) begin
                lowrun += segs[k].n;
                if (in_sync) begin
                    if (lowrun >= TLATCH) begin
                        in_sync = 1'b0; in_frame = 1'b0; nbits = 0; npix = 0;
                    end
                end else if (in_frame && lowrun >= TLATCH) begin
                    exp_frm.push_back('{cnt: (npix > NLED) ? NLED : npix, err: (nbits != 0) ? 1 : 0});
                    if (nbits != 0) exp_err++;
                    in_frame = 1'b0; nbits = 0; npix = 0;
                end
            end else begin
                if (in_sync) begin
                    lowrun = 0;
                end else if (segs[k].n < TH_MIN) begin
                    // glitch: no effect, low time keeps accumulating
                end else if (segs[k].n > T1H_MAX) begin
                    exp_err++;
                    in_sync = 1'b1; in_frame = 1'b0; lowrun = 0; nbits = 0; npix = 0;
                end else begin
                    cur = {cur[22:0], (segs[k].n > T0H_MAX) ? 1'b1 : 1'b0};
                    nbits++;
                    in_frame = 1'b1;
                    lowrun = 0;
                    if (nbits == 24) begin
                        nbits = 0;
                        if (npix < NLED) exp_pix.push_back('{data: cur, idx: npix});
                        else if (npix == NLED) exp_err++;
                        npix++;
                    end
                end
            end
        end
    endtask

    task automatic play();
        foreach (segs[k]) begin
            if (segs[k].lvl == 2) begin
                rst_n = 1'b0;
                #1;
                chk("rst_pixel_data", 32'(pixel_data), 32'h0);
                chk("rst_pixel_index", 32'(pixel_index), 32'h0);
                chk("rst_pixel_valid", 32'(pixel_valid), 32'h0);
                chk("rst_frame_done", 32'(frame_done), 32'h0);
                chk("rst_pixel_count", 32'(pixel_count), 32'h0);
                chk("rst_error", 32'(error), 32'h0);
                repeat (segs[k].n) @(negedge clk);
                rst_n = 1'b1;
            end else begin
                din = segs[k].lvl[0];
                repeat (segs[k].n) @(negedge clk);
            end
        end
        din = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        int bp;
        int bf;
        int be;
        int bc;
        int np;
        int nf;
        vecs[0] = '{kind: 0, exp_valid: 1,  exp_frames: 1, exp_errors: 0, exp_count: 1};
        vecs[1] = '{kind: 1, exp_valid: 64, exp_frames: 1, exp_errors: 1, exp_count: 64};
        vecs[2] = '{kind: 2, exp_valid: 3,  exp_frames: 1, exp_errors: 1, exp_count: 1};
        vecs[3] = '{kind: 3, exp_valid: 0,  exp_frames: 1, exp_errors: 1, exp_count: 0};
        vecs[4] = '{kind: 4, exp_valid: 5,  exp_frames: 1, exp_errors: 0, exp_count: 5};
        vecs[5] = '{kind: 5, exp_valid: 6,  exp_frames: 1, exp_errors: 0, exp_count: 2};

        repeat (3) @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            build(vecs[v].kind);
            model_run();
            bp = dut_pix.size();
            bf = dut_frm.size();
            be = dut_err;
            bc = dut_clash;
            play();
            np = dut_pix.size() - bp;
            nf = dut_frm.size() - bf;
            chk($sformatf("s%0d_valid_count", v), 32'(np), 32'(vecs[v].exp_valid));
            chk($sformatf("s%0d_frame_count", v), 32'(nf), 32'(vecs[v].exp_frames));
            chk($sformatf("s%0d_error_count", v), 32'(dut_err - be), 32'(vecs[v].exp_errors));
            chk($sformatf("s%0d_error_model", v), 32'(dut_err - be), 32'(exp_err));
            chk($sformatf("s%0d_clash", v), 32'(dut_clash - bc), 32'h0);
            chk($sformatf("s%0d_pixel_count_out", v), 32'(pixel_count), 32'(vecs[v].exp_count));
            if (v == 0) chk("s0_data_ff0000", 32'(exp_pix[0].data), 32'hFF0000);
            for (int k = 0; k < np && k < exp_pix.size(); k++) begin
                chk($sformatf("s%0d_px%0d_data", v, k), 32'(dut_pix[bp + k].data), 32'(exp_pix[k].data));
                chk($sformatf("s%0d_px%0d_index", v, k), 32'(dut_pix[bp + k].idx), 32'(exp_pix[k].idx));
            end
            for (int k = 0; k < nf && k < exp_frm.size(); k++) begin
                chk($sformatf("s%0d_frm%0d_count", v, k), 32'(dut_frm[bf + k].cnt), 32'(exp_frm[k].cnt));
                chk($sformatf("s%0d_frm%0d_err", v, k), 32'(dut_frm[bf + k].err), 32'(exp_frm[k].err));
            end
            $display("scenario %0d: pixels=%0d frames=%0d error_strobes=%0d", v, np, nf, dut_err - be);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
